// File: rtl/dram_arbiter.sv
// Two-way arbiter for the single-port 32K x 8 bitmap DRAM.
// Latency: grant is combinational in the issue cycle; result/done pulse 3 cycles after issue.
// Backpressure: video has priority; the CPU is guaranteed a slot after MAX_VID_RUN video grants.
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   vid_req/vid_addr -> vid_ack         video read request, combinational accept
//   vid_valid/vid_data                  one-cycle result pulse, data held until next result
//   cpu_req/cpu_we/cpu_addr/cpu_din     CPU access request (read or write)
//   cpu_gnt                             combinational grant, operands sampled this cycle
//   cpu_done/cpu_dout                   one-cycle completion pulse, read data
//   ram_we/ram_addr/ram_din/ram_dout    registered interface to the DRAM macro
module dram_arbiter #(
  parameter int unsigned MAX_VID_RUN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  // video fetch path
  input  logic        vid_req,
  input  logic [14:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_valid,
  output logic [7:0]  vid_data,
  // CPU bus interface
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic [7:0]  cpu_dout,
  // DRAM macro
  output logic        ram_we,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  localparam logic [3:0] MAX_RUN = 4'(MAX_VID_RUN);

  // What kind of access occupies each pipeline stage.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_VID    = 2'd1,
    TAG_CPU_RD = 2'd2,
    TAG_CPU_WR = 2'd3
  } tag_e;

  // Issue stage registers (drive the RAM directly)
  logic        ram_we_q,   ram_we_d;
  logic [14:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_din_q,  ram_din_d;

  // Pipeline tags: stage1 = RAM sampling address, stage2 = RAM data valid
  tag_e        tag1_q, tag1_d;
  tag_e        tag2_q;

  // Result registers
  logic        vid_valid_q, vid_valid_d;
  logic [7:0]  vid_data_q,  vid_data_d;
  logic        cpu_done_q,  cpu_done_d;
  logic [7:0]  cpu_dout_q,  cpu_dout_d;

  // Arbitration state
  logic [3:0]  run_cnt_q, run_cnt_d;
  logic        cpu_busy_q, cpu_busy_d;

  // Combinational grant
  logic        cpu_wait;
  logic        gnt_cpu;
  logic        gnt_vid;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  // Grants are qualified by reset_n so that no requester sees an accept while
  // the pipeline is held in reset; the flops ignore them anyway.
  always_comb begin
    cpu_wait = cpu_req & ~cpu_busy_q;
    gnt_cpu  = 1'b0;
    gnt_vid  = 1'b0;
    if (reset_n) begin
      if (cpu_wait && (!vid_req || (run_cnt_q == MAX_RUN))) begin
        gnt_cpu = 1'b1;
      end else if (vid_req) begin
        gnt_vid = 1'b1;
      end
    end
  end

  assign vid_ack = gnt_vid;
  assign cpu_gnt = gnt_cpu;

  // ---------------------------------------------------------------------------
  // Starvation counter and CPU busy flag
  // ---------------------------------------------------------------------------
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (gnt_cpu || !cpu_wait) begin
      run_cnt_d = 4'd0;
    end else if (gnt_vid && (run_cnt_q != MAX_RUN)) begin
      run_cnt_d = run_cnt_q + 4'd1;
    end
  end

  // Busy drops on the edge that raises cpu_done, so a request standing in
  // the done cycle is already eligible for a fresh grant.
  always_comb begin
    cpu_busy_d = cpu_busy_q;
    if (gnt_cpu) begin
      cpu_busy_d = 1'b1;
    end else if ((tag2_q == TAG_CPU_RD) || (tag2_q == TAG_CPU_WR)) begin
      cpu_busy_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue stage: load RAM controls from the winner
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_we_d   = gnt_cpu & cpu_we;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    tag1_d     = TAG_NONE;
    if (gnt_cpu) begin
      ram_addr_d = cpu_addr;
      ram_din_d  = cpu_din;
      tag1_d     = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
    end else if (gnt_vid) begin
      // Video never writes, so the write data register is left alone.
      ram_addr_d = vid_addr;
      tag1_d     = TAG_VID;
    end
  end

  // ---------------------------------------------------------------------------
  // Result stage: route registered RAM data to its owner
  // ---------------------------------------------------------------------------
  always_comb begin
    vid_valid_d = (tag2_q == TAG_VID);
    vid_data_d  = vid_data_q;
    cpu_done_d  = (tag2_q == TAG_CPU_RD) || (tag2_q == TAG_CPU_WR);
    cpu_dout_d  = cpu_dout_q;
    if (tag2_q == TAG_VID) begin
      vid_data_d = ram_dout;
    end
    // A write completes with a done pulse but leaves the read data untouched.
    if (tag2_q == TAG_CPU_RD) begin
      cpu_dout_d = ram_dout;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 15'd0;
      ram_din_q   <= 8'd0;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      vid_valid_q <= 1'b0;
      vid_data_q  <= 8'd0;
      cpu_done_q  <= 1'b0;
      cpu_dout_q  <= 8'd0;
      run_cnt_q   <= 4'd0;
      cpu_busy_q  <= 1'b0;
    end else begin
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      cpu_done_q  <= cpu_done_d;
      cpu_dout_q  <= cpu_dout_d;
      run_cnt_q   <= run_cnt_d;
      cpu_busy_q  <= cpu_busy_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign vid_valid = vid_valid_q;
  assign vid_data  = vid_data_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_dout  = cpu_dout_q;

endmodule
